// File: rtl/regfile_wb_arb.sv
// Purpose : merge two writeback sources (A = ALU, B = memory load) onto one register-file write port.
// Latency : request accepted at edge N -> rf_wrt asserted after edge N+1 (register file writes at N+2).
// Backpres: each source owns a 2-entry FIFO; its ready is registered as (count < 2), never a same-cycle pass-through.
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   a_valid/a_rd/a_data/a_ready  source A writeback request channel (valid/ready)
//   b_valid/b_rd/b_data/b_ready  source B writeback request channel (valid/ready)
//   rf_wrt/rf_rd/rf_din          register-file write port (one-cycle write pulse, index and data hold otherwise)
//   pend_mask                    bit i set while a write to register i is queued or on the write port

// Purpose : 2-entry FIFO whose entries are all visible, so the owner can build hazard masks from them.
// Latency : pushed entry is at the head after the pushing edge.
// Backpres: ready is a register equal to (count < 2) for the coming cycle; a pop does not reopen it in the same cycle.
module regfile_wb_fifo #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic             ready,
    output logic [1:0]       ent_vld,
    output logic [1:0][W-1:0] ent_dat
);

    logic [1:0] cnt;
    logic [1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + 2'd1;
        end else if (!push && pop) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    // Slot 0 is always the head; a pop shifts slot 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            ready   <= 1'b0;
            ent_dat <= '0;
        end else begin
            cnt   <= cnt_nxt;
            ready <= (cnt_nxt < 2'd2);
            case ({push, pop})
                2'b01: begin
                    ent_dat[0] <= ent_dat[1];
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        ent_dat[0] <= push_dat;
                    end else begin
                        ent_dat[1] <= push_dat;
                    end
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever remains.
                    if (cnt == 2'd2) begin
                        ent_dat[0] <= ent_dat[1];
                        ent_dat[1] <= push_dat;
                    end else begin
                        ent_dat[0] <= push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ent_vld = {cnt == 2'd2, cnt != 2'd0};

endmodule

module regfile_wb_arb #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int DROP_R0 = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_rd,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_rd,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    output logic                  rf_wrt,
    output logic [ADDR_W-1:0]     rf_rd,
    output logic [DATA_W-1:0]     rf_din,
    output logic [2**ADDR_W-1:0]  pend_mask
);

    localparam int EW = ADDR_W + DATA_W;

    logic              a_push;
    logic              b_push;
    logic              gnt_a;
    logic              gnt_b;
    logic              ptr;        // 0 = A has priority, 1 = B has priority
    logic [1:0]        a_vld;
    logic [1:0]        b_vld;
    logic [1:0][EW-1:0] a_ent;
    logic [1:0][EW-1:0] b_ent;

    // Register-0 writes complete the handshake but never enter the queue.
    assign a_push = a_valid && a_ready && !((DROP_R0 != 0) && (a_rd == '0));
    assign b_push = b_valid && b_ready && !((DROP_R0 != 0) && (b_rd == '0));

    regfile_wb_fifo #(.W(EW)) u_fifo_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (a_push),
        .push_dat ({a_rd, a_data}),
        .pop      (gnt_a),
        .ready    (a_ready),
        .ent_vld  (a_vld),
        .ent_dat  (a_ent)
    );

    regfile_wb_fifo #(.W(EW)) u_fifo_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (b_push),
        .push_dat ({b_rd, b_data}),
        .pop      (gnt_b),
        .ready    (b_ready),
        .ent_vld  (b_vld),
        .ent_dat  (b_ent)
    );

    // Round-robin only matters when both heads are present; a lone head always wins.
    assign gnt_a = a_vld[0] && (!b_vld[0] || !ptr);
    assign gnt_b = b_vld[0] && (!a_vld[0] ||  ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            rf_wrt <= 1'b0;
            rf_rd  <= '0;
            rf_din <= '0;
        end else begin
            rf_wrt <= gnt_a || gnt_b;
            if (gnt_a) begin
                rf_rd  <= a_ent[0][EW-1:DATA_W];
                rf_din <= a_ent[0][DATA_W-1:0];
                ptr    <= 1'b1;
            end else if (gnt_b) begin
                rf_rd  <= b_ent[0][EW-1:DATA_W];
                rf_din <= b_ent[0][DATA_W-1:0];
                ptr    <= 1'b0;
            end
        end
    end

    // Hazard mask: every queued index plus the index currently on the write port.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (a_vld[i]) begin
                pend_mask[a_ent[i][EW-1:DATA_W]] = 1'b1;
            end
            if (b_vld[i]) begin
                pend_mask[b_ent[i][EW-1:DATA_W]] = 1'b1;
            end
        end
        if (rf_wrt) begin
            pend_mask[rf_rd] = 1'b1;
        end
    end

endmodule
